mul_wb_buffer: RTL and testbench

- Receiving end of the multiplier pipeline: captures each instruction leaving the last mul stage and holds it in a small FIFO.
- Presents the head entry to the reorder buffer writeback port through a valid/ready handshake.
- The mul pipeline has no backpressure, so the block runs a credit counter and raises a stall to the mul issue logic before the buffer could overflow.

---
 rtl/mul_wb_buffer_pkg.sv | 38 +++
 rtl/mul_wb_fifo.sv | 72 +++++++
 rtl/mul_wb_buffer.sv | 122 ++++++++++++
 tb/tb_mul_wb_buffer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_wb_buffer_pkg.sv
// Shared types and constants for the multiplier writeback buffer.
package mul_wb_buffer_pkg;

    localparam int MUL_STAGES   = 5;
    localparam int MUL_WB_DEPTH = 4;

    localparam int ROB_ID_W    = 5;
    localparam int PC_W        = 32;
    localparam int REG_ADDR_W  = 5;
    localparam int REG_DATA_W  = 32;

    typedef struct packed {
        logic       valid;
        logic [3:0] cause;
    } fetch_xcpt_t;

    typedef struct packed {
        logic valid;
        logic illegal_instr;
    } decode_xcpt_t;

    typedef struct packed {
        logic valid;
        logic overflow;
    } mul_xcpt_t;

    // One buffered mul result, stored as a single packed word.
    typedef struct packed {
        logic [ROB_ID_W-1:0]   id;
        logic [PC_W-1:0]       pc;
        logic [REG_ADDR_W-1:0] dest;
        logic [REG_DATA_W-1:0] data;
        fetch_xcpt_t           xcpt_fetch;
        decode_xcpt_t          xcpt_decode;
        mul_xcpt_t             xcpt_mul;
    } mul_wb_entry_t;

endpackage

// File: rtl/mul_wb_fifo.sv
// Generic storage array with read/write pointers and an occupancy counter.
// Full/empty come from the counter so pointers can wrap freely.
module mul_wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        wr_data,
    output logic [WIDTH-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty,
    output logic                    full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    // A pop on an empty buffer is ignored; a push into a full buffer only
    // lands when the head leaves in the same cycle, otherwise it is dropped.
    assign rd_en   = pop && !empty;
    assign wr_en   = push && (!full || rd_en);
    assign rd_data = mem[rd_ptr];

    // Storage array; cleared on reset so the head reads as zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; flush overrides any push or pop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mul_wb_buffer.sv
// Writeback buffer at the tail of the multiplier pipeline. Captures each
// result leaving the last mul stage, presents the oldest one to the ROB, and
// throttles mul issue with a credit count since the pipeline cannot stall.
//
// ROB handshake: rob_valid_out means the rob_* fields hold the oldest entry
// and stay stable until taken; the entry is taken at a rising edge where
// rob_valid_out and rob_ready_in are both high. rob_ready_in may be high at
// any time and has no effect while rob_valid_out is low.
module mul_wb_buffer
    import mul_wb_buffer_pkg::*;
#(
    parameter int DEPTH      = MUL_WB_DEPTH,
    parameter int MUL_STAGES = mul_wb_buffer_pkg::MUL_STAGES
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush_in,
    input  logic                  mul_issue_in,
    output logic                  mul_stall_out,
    input  logic                  instr_valid_in,
    input  logic [ROB_ID_W-1:0]   instr_id_in,
    input  logic [PC_W-1:0]       program_counter_in,
    input  logic [REG_ADDR_W-1:0] dest_reg_in,
    input  logic [REG_DATA_W-1:0] data_result_in,
    input  fetch_xcpt_t           xcpt_fetch_in,
    input  decode_xcpt_t          xcpt_decode_in,
    input  mul_xcpt_t             xcpt_mul_in,
    output logic                  rob_valid_out,
    input  logic                  rob_ready_in,
    output logic [ROB_ID_W-1:0]   rob_instr_id_out,
    output logic [PC_W-1:0]       rob_program_counter_out,
    output logic [REG_ADDR_W-1:0] rob_dest_reg_out,
    output logic [REG_DATA_W-1:0] rob_data_result_out,
    output fetch_xcpt_t           rob_xcpt_fetch_out,
    output decode_xcpt_t          rob_xcpt_decode_out,
    output mul_xcpt_t             rob_xcpt_mul_out
);

    localparam int ENTRY_W = $bits(mul_wb_entry_t);
    localparam int OCC_W   = $clog2(DEPTH) + 1;
    localparam int IF_W    = $clog2(MUL_STAGES + 1) + 1;
    localparam int SUM_W   = ((OCC_W > IF_W) ? OCC_W : IF_W) + 1;

    mul_wb_entry_t     in_entry;
    mul_wb_entry_t     head_entry;
    logic [ENTRY_W-1:0] head_bits;
    logic [OCC_W-1:0]  occupancy;
    logic [IF_W-1:0]   inflight;
    logic              fifo_empty;
    logic              fifo_full;

    assign in_entry = '{
        id:          instr_id_in,
        pc:          program_counter_in,
        dest:        dest_reg_in,
        data:        data_result_in,
        xcpt_fetch:  xcpt_fetch_in,
        xcpt_decode: xcpt_decode_in,
        xcpt_mul:    xcpt_mul_in
    };

    mul_wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .flush   (flush_in),
        .push    (instr_valid_in),
        .pop     (rob_ready_in),
        .wr_data (in_entry),
        .rd_data (head_bits),
        .count   (occupancy),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign head_entry              = mul_wb_entry_t'(head_bits);
    assign rob_valid_out           = !fifo_empty;
    assign rob_instr_id_out        = head_entry.id;
    assign rob_program_counter_out = head_entry.pc;
    assign rob_dest_reg_out        = head_entry.dest;
    assign rob_data_result_out     = head_entry.data;
    assign rob_xcpt_fetch_out      = head_entry.xcpt_fetch;
    assign rob_xcpt_decode_out     = head_entry.xcpt_decode;
    assign rob_xcpt_mul_out        = head_entry.xcpt_mul;

    // Count of mul instructions issued but not yet arrived. The decrement
    // holds at zero so an unmatched arrival cannot wrap the count and
    // wedge the stall high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inflight <= '0;
        end else if (flush_in) begin
            inflight <= '0;
        end else begin
            case ({mul_issue_in, instr_valid_in})
                2'b10:   inflight <= inflight + IF_W'(1);
                2'b01:   inflight <= (inflight != '0) ? inflight - IF_W'(1) : inflight;
                default: inflight <= inflight;
            endcase
        end
    end

    // Every buffered or in-flight instruction holds a slot; stop issue when
    // all slots are spoken for.
    assign mul_stall_out = (SUM_W'(occupancy) + SUM_W'(inflight)) >= SUM_W'(DEPTH);

    // Issue must respect the stall.
    issue_while_stalled_a : assert property (
        @(posedge clock) disable iff (reset || flush_in)
        !(mul_issue_in && mul_stall_out)
    );

    // An arrival into a full buffer with no pop cannot happen under the
    // credit rule; if it did, the entry would be dropped.
    arrival_into_full_a : assert property (
        @(posedge clock) disable iff (reset || flush_in)
        !(instr_valid_in && fifo_full && !rob_ready_in)
    );

endmodule

// File: tb/tb_mul_wb_buffer.sv
// Bench for mul_wb_buffer: a queue-based model of the buffer plus a simple
// mul pipeline delay line on the stimulus side.
module tb_mul_wb_buffer;
    import mul_wb_buffer_pkg::*;

    localparam int DEPTH  = 4;
    localparam int STAGES = 5;
    localparam int EW     = $bits(mul_wb_entry_t);

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic                  flush_in = 1'b0;
    logic                  mul_issue_in = 1'b0;
    logic                  mul_stall_out;
    logic                  instr_valid_in = 1'b0;
    logic [ROB_ID_W-1:0]   instr_id_in = '0;
    logic [PC_W-1:0]       program_counter_in = '0;
    logic [REG_ADDR_W-1:0] dest_reg_in = '0;
    logic [REG_DATA_W-1:0] data_result_in = '0;
    fetch_xcpt_t           xcpt_fetch_in = '0;
    decode_xcpt_t          xcpt_decode_in = '0;
    mul_xcpt_t             xcpt_mul_in = '0;
    logic                  rob_valid_out;
    logic                  rob_ready_in = 1'b0;
    logic [ROB_ID_W-1:0]   rob_instr_id_out;
    logic [PC_W-1:0]       rob_program_counter_out;
    logic [REG_ADDR_W-1:0] rob_dest_reg_out;
    logic [REG_DATA_W-1:0] rob_data_result_out;
    fetch_xcpt_t           rob_xcpt_fetch_out;
    decode_xcpt_t          rob_xcpt_decode_out;
    mul_xcpt_t             rob_xcpt_mul_out;

    mul_wb_buffer #(.DEPTH(DEPTH), .MUL_STAGES(STAGES)) dut (
        .clock                   (clock),
        .reset                   (reset),
        .flush_in                (flush_in),
        .mul_issue_in            (mul_issue_in),
        .mul_stall_out           (mul_stall_out),
        .instr_valid_in          (instr_valid_in),
        .instr_id_in             (instr_id_in),
        .program_counter_in      (program_counter_in),
        .dest_reg_in             (dest_reg_in),
        .data_result_in          (data_result_in),
        .xcpt_fetch_in           (xcpt_fetch_in),
        .xcpt_decode_in          (xcpt_decode_in),
        .xcpt_mul_in             (xcpt_mul_in),
        .rob_valid_out           (rob_valid_out),
        .rob_ready_in            (rob_ready_in),
        .rob_instr_id_out        (rob_instr_id_out),
        .rob_program_counter_out (rob_program_counter_out),
        .rob_dest_reg_out        (rob_dest_reg_out),
        .rob_data_result_out     (rob_data_result_out),
        .rob_xcpt_fetch_out      (rob_xcpt_fetch_out),
        .rob_xcpt_decode_out     (rob_xcpt_decode_out),
        .rob_xcpt_mul_out        (rob_xcpt_mul_out)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    // ---------------- bookkeeping ----------------
    int chk_cnt  = 0;
    int pass_cnt = 0;
    int cyc      = 0;

    logic [EW-1:0] exp_q[$];
    int            m_inflight = 0;

    typedef struct {
        mul_wb_entry_t e;
        int            at;
    } pend_t;
    pend_t pend_q[$];

    mul_wb_entry_t null_e = '0;
    mul_wb_entry_t sop_e;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic mul_wb_entry_t mk(input int id);
        logic [31:0]   v;
        mul_wb_entry_t e;
        v = id;
        e.id                      = v[ROB_ID_W-1:0];
        e.pc                      = PC_W'(32'h2000 + (v << 2));
        e.dest                    = REG_ADDR_W'(v + 32'd1);
        e.data                    = REG_DATA_W'(32'hA500_0000 | v);
        e.xcpt_fetch.valid        = v[0];
        e.xcpt_fetch.cause        = v[3:0];
        e.xcpt_decode.valid       = v[1];
        e.xcpt_decode.illegal_instr = v[0];
        e.xcpt_mul.valid          = v[2];
        e.xcpt_mul.overflow       = v[1];
        return e;
    endfunction

    // ---------------- driver tasks ----------------
    // One clock cycle of stimulus. Issued instructions re-appear on the
    // arrival port STAGES cycles later unless flushed; 'inject' drives an
    // arrival directly.
    task automatic cycle(input logic issue, input logic ready, input logic flush,
                         input logic inject, input mul_wb_entry_t inj_e, input mul_wb_entry_t iss_e);
        pend_t         p;
        mul_wb_entry_t a;
        logic          arrive;
        mul_issue_in = issue;
        rob_ready_in = ready;
        flush_in     = flush;
        if (issue) begin
            p.e  = iss_e;
            p.at = cyc + STAGES;
            pend_q.push_back(p);
        end
        arrive = 1'b0;
        a      = mul_wb_entry_t'(EW'({$urandom, $urandom, $urandom}));
        if (inject) begin
            arrive = 1'b1;
            a      = inj_e;
        end else if (pend_q.size() != 0 && pend_q[0].at == cyc) begin
            arrive = 1'b1;
            a      = pend_q[0].e;
            void'(pend_q.pop_front());
        end
        instr_valid_in     = arrive;
        instr_id_in        = a.id;
        program_counter_in = a.pc;
        dest_reg_in        = a.dest;
        data_result_in     = a.data;
        xcpt_fetch_in      = a.xcpt_fetch;
        xcpt_decode_in     = a.xcpt_decode;
        xcpt_mul_in        = a.xcpt_mul;
        @(posedge clock);
        if (flush) pend_q.delete();
        #2;
        cyc++;
    endtask

    task automatic idle(input logic ready);
        cycle(1'b0, ready, 1'b0, 1'b0, null_e, null_e);
    endtask

    task automatic issue_op(input mul_wb_entry_t e, input logic ready);
        cycle(1'b1, ready, 1'b0, 1'b0, null_e, e);
    endtask

    task automatic inject_op(input mul_wb_entry_t e, input logic ready);
        cycle(1'b0, ready, 1'b0, 1'b1, e, null_e);
    endtask

    task automatic set_idle_inputs();
        mul_issue_in   = 1'b0;
        instr_valid_in = 1'b0;
        rob_ready_in   = 1'b0;
        flush_in       = 1'b0;
    endtask

    // Issue id=3 with ready held high: visible exactly in the cycle after
    // its arrival edge, gone the cycle after.
    task automatic run_single_op(input string tag);
        issue_op(sop_e, 1'b1);
        repeat (4) idle(1'b1);
        check({tag, "_pre_valid"}, 128'(rob_valid_out), 128'(1'b0));
        idle(1'b1);
        check({tag, "_valid"}, 128'(rob_valid_out), 128'(1'b1));
        check({tag, "_id"},    128'(rob_instr_id_out), 128'(5'd3));
        check({tag, "_pc"},    128'(rob_program_counter_out), 128'(32'h1000));
        check({tag, "_dest"},  128'(rob_dest_reg_out), 128'(5'd7));
        check({tag, "_data"},  128'(rob_data_result_out), 128'(32'h2A));
        check({tag, "_stall"}, 128'(mul_stall_out), 128'(1'b0));
        idle(1'b1);
        check({tag, "_post_valid"}, 128'(rob_valid_out), 128'(1'b0));
    endtask

    // ---------------- model ----------------
    // Expected buffer contents as a queue; in-flight as issue minus arrivals.
    initial begin
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                exp_q.delete();
                m_inflight = 0;
            end else if (flush_in) begin
                exp_q.delete();
                m_inflight = 0;
            end else begin
                if (exp_q.size() != 0 && rob_ready_in) void'(exp_q.pop_front());
                if (instr_valid_in && exp_q.size() < DEPTH)
                    exp_q.push_back({instr_id_in, program_counter_in, dest_reg_in, data_result_in,
                                     xcpt_fetch_in, xcpt_decode_in, xcpt_mul_in});
                if (mul_issue_in && !instr_valid_in) m_inflight++;
                else if (instr_valid_in && !mul_issue_in && m_inflight > 0) m_inflight--;
            end
        end
    end

    // ---------------- scoreboard compare ----------------
    initial begin
        logic [EW-1:0] head;
        forever begin
            @(negedge clock);
            if (!reset) begin
                head = {rob_instr_id_out, rob_program_counter_out, rob_dest_reg_out, rob_data_result_out,
                        rob_xcpt_fetch_out, rob_xcpt_decode_out, rob_xcpt_mul_out};
                check("cmp_valid", 128'(rob_valid_out), 128'(exp_q.size() != 0));
                check("cmp_stall", 128'(mul_stall_out), 128'((exp_q.size() + m_inflight) >= DEPTH));
                if (exp_q.size() != 0) check("cmp_head", 128'(head), 128'(exp_q[0]));
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        sop_e = '{id: 5'd3, pc: 32'h1000, dest: 5'd7, data: 32'h2A,
                  xcpt_fetch: '0, xcpt_decode: '0, xcpt_mul: '0};

        repeat (2) @(posedge clock);
        #2;
        check("rst_valid", 128'(rob_valid_out), 128'(1'b0));
        check("rst_stall", 128'(mul_stall_out), 128'(1'b0));
        check("rst_id",    128'(rob_instr_id_out), 128'(0));
        check("rst_pc",    128'(rob_program_counter_out), 128'(0));
        check("rst_data",  128'(rob_data_result_out), 128'(0));
        reset = 1'b0;

        // Single op
        run_single_op("single");

        // Credit stall: four issues with the ROB not accepting
        for (int i = 0; i < 4; i++) begin
            if (i == 3) check("credit_stall_at3", 128'(mul_stall_out), 128'(1'b0));
            issue_op(mk(i), 1'b0);
        end
        check("credit_stall_at4", 128'(mul_stall_out), 128'(1'b1));
        repeat (5) idle(1'b0);
        check("credit_full_valid", 128'(rob_valid_out), 128'(1'b1));
        check("credit_full_stall", 128'(mul_stall_out), 128'(1'b1));
        for (int i = 0; i < 4; i++) begin
            check("credit_pop_id", 128'(rob_instr_id_out), 128'(i));
            idle(1'b1);
        end
        check("credit_drained_valid", 128'(rob_valid_out), 128'(1'b0));
        check("credit_drained_stall", 128'(mul_stall_out), 128'(1'b0));

        // Full buffer with push and pop together, across pointer wrap
        for (int i = 0; i < 4; i++) inject_op(mk(8 + i), 1'b0);
        check("full_head", 128'(rob_instr_id_out), 128'(8));
        for (int i = 4; i < 8; i++) begin
            check("full_pp_head", 128'(rob_instr_id_out), 128'(i + 4));
            inject_op(mk(8 + i), 1'b1);
            check("full_pp_stall", 128'(mul_stall_out), 128'(1'b1));
        end
        for (int i = 0; i < 4; i++) begin
            check("full_drain_id", 128'(rob_instr_id_out), 128'(12 + i));
            check("full_drain_pc", 128'(rob_program_counter_out), 128'(32'h2000 + 4 * (12 + i)));
            idle(1'b1);
        end
        check("full_drained", 128'(rob_valid_out), 128'(1'b0));

        // Flush with two buffered and two in flight
        for (int i = 0; i < 4; i++) issue_op(mk(20 + i), 1'b0);
        repeat (3) idle(1'b0);
        check("flush_pre_valid", 128'(rob_valid_out), 128'(1'b1));
        check("flush_pre_stall", 128'(mul_stall_out), 128'(1'b1));
        check("flush_pre_id",    128'(rob_instr_id_out), 128'(20));
        cycle(1'b0, 1'b1, 1'b1, 1'b0, null_e, null_e);
        check("flush_valid", 128'(rob_valid_out), 128'(1'b0));
        check("flush_stall", 128'(mul_stall_out), 128'(1'b0));
        repeat (2) idle(1'b1);
        check("flush_quiet", 128'(rob_valid_out), 128'(1'b0));
        run_single_op("post_flush");

        // Asynchronous reset mid-cycle with entries buffered and in flight
        for (int i = 0; i < 3; i++) inject_op(mk(24 + i), 1'b0);
        issue_op(mk(27), 1'b0);
        check("rstmid_pre_stall", 128'(mul_stall_out), 128'(1'b1));
        check("rstmid_pre_valid", 128'(rob_valid_out), 128'(1'b1));
        set_idle_inputs();
        #1;
        reset = 1'b1;
        pend_q.delete();
        #1;
        check("rstmid_valid", 128'(rob_valid_out), 128'(1'b0));
        check("rstmid_stall", 128'(mul_stall_out), 128'(1'b0));
        check("rstmid_id",    128'(rob_instr_id_out), 128'(0));
        check("rstmid_occ",   128'(dut.u_fifo.count), 128'(0));
        check("rstmid_infl",  128'(dut.inflight), 128'(0));
        @(posedge clock);
        #2;
        reset = 1'b0;
        idle(1'b1);
        run_single_op("post_reset");

        set_idle_inputs();
        repeat (2) @(posedge clock);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
